rename_table_ckpt: RTL

RENAME_TABLE_CKPT -- requirements
Module: rename_table_ckpt

---
 rtl/rename_table_ckpt.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/rename_table_ckpt.sv
// Register rename table: areg->preg map with pending bits, free list and lowest-free allocator.
// Defining RENAME_TABLE_CKPT_EN adds a single-slot checkpoint/restore shadow of map and free list.
module rename_table_ckpt #(
  parameter int unsigned p_num_phys_regs  = 64,
  parameter int unsigned p_num_lookup     = 4,
  parameter int unsigned p_phys_addr_bits = $clog2(p_num_phys_regs)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [4:0]                  alloc_areg,
  input  logic                        alloc_en,
  output logic                        alloc_rdy,
  output logic [p_phys_addr_bits-1:0] alloc_preg,
  output logic [p_phys_addr_bits-1:0] alloc_ppreg,
  input  logic [4:0]                  lookup_areg    [p_num_lookup],
  input  logic                        lookup_en      [p_num_lookup],
  output logic [p_phys_addr_bits-1:0] lookup_preg    [p_num_lookup],
  output logic                        lookup_pending [p_num_lookup],
  input  logic                        complete_val,
  input  logic [p_phys_addr_bits-1:0] complete_preg,
  input  logic [p_phys_addr_bits-1:0] complete_ppreg,
  input  logic                        ckpt_en,
  input  logic                        restore_en,
  output logic                        ckpt_valid
);

  localparam int unsigned P  = p_phys_addr_bits;
  localparam int unsigned NP = p_num_phys_regs;

  if (p_num_phys_regs <= 32) begin : g_bad_num_phys_regs
    $fatal(1, "rename_table_ckpt: p_num_phys_regs must exceed 32");
  end
  if (p_num_lookup < 1) begin : g_bad_num_lookup
    $fatal(1, "rename_table_ckpt: p_num_lookup must be at least 1");
  end

  // Entry 0 is reset to preg 0 and never written, so it reads as the hardwired zero register.
  logic [P-1:0]  map_preg_q [32];
  logic [P-1:0]  map_preg_d [32];
  logic [31:0]   map_pend_q, map_pend_d;
  logic [NP-1:0] free_q, free_d;
  logic          any_free_c;
  logic          alloc_fire_c;
  logic          unused_lookup_en;

  // Lowest-index free preg; preg 0 is never free.
  always_comb begin
    alloc_preg = '0;
    any_free_c = 1'b0;
    for (int i = 1; i < int'(NP); i++) begin
      if (free_q[i] && !any_free_c) begin
        alloc_preg = P'(i);
        any_free_c = 1'b1;
      end
    end
  end

  assign alloc_ppreg = map_preg_q[alloc_areg];

  always_comb begin
    unused_lookup_en = 1'b0;
    for (int k = 0; k < int'(p_num_lookup); k++) begin
      lookup_preg[k]    = map_preg_q[lookup_areg[k]];
      lookup_pending[k] = map_pend_q[lookup_areg[k]];
      unused_lookup_en  = unused_lookup_en | lookup_en[k];
    end
  end

`ifdef RENAME_TABLE_CKPT_EN
  logic [P-1:0]  sh_preg_q [32];
  logic [P-1:0]  sh_preg_d [32];
  logic [31:0]   sh_pend_q, sh_pend_d;
  logic [NP-1:0] sh_free_q, sh_free_d;
  logic          ckpt_valid_q, ckpt_valid_d;
  logic          do_restore_c;

  assign alloc_rdy  = any_free_c & ~restore_en;
  assign ckpt_valid = ckpt_valid_q;
`else
  logic unused_ckpt_ctrl;

  assign alloc_rdy        = any_free_c;
  assign ckpt_valid       = 1'b0;
  assign unused_ckpt_ctrl = ckpt_en ^ restore_en;
`endif

  assign alloc_fire_c = alloc_en & alloc_rdy & (alloc_areg != 5'd0);

  // Completion is applied first so a same-cycle allocation wins on both the map entry and the free bit.
  always_comb begin
    map_preg_d = map_preg_q;
    map_pend_d = map_pend_q;
    free_d     = free_q;
    if (complete_val) begin
      for (int i = 0; i < 32; i++) begin
        if (map_preg_q[i] == complete_preg) map_pend_d[i] = 1'b0;
      end
      if (complete_ppreg != '0) free_d[complete_ppreg] = 1'b1;
    end
    if (alloc_fire_c) begin
      map_preg_d[alloc_areg] = alloc_preg;
      map_pend_d[alloc_areg] = 1'b1;
      free_d[alloc_preg]     = 1'b0;
    end
`ifdef RENAME_TABLE_CKPT_EN
    sh_preg_d    = sh_preg_q;
    sh_pend_d    = sh_pend_q;
    sh_free_d    = sh_free_q;
    ckpt_valid_d = ckpt_valid_q;
    do_restore_c = restore_en & ckpt_valid_q;
    // Shadow tracks completions; its contents are irrelevant while no checkpoint is held.
    if (complete_val) begin
      for (int i = 0; i < 32; i++) begin
        if (sh_preg_q[i] == complete_preg) sh_pend_d[i] = 1'b0;
      end
      if (complete_ppreg != '0) sh_free_d[complete_ppreg] = 1'b1;
    end
    if (do_restore_c) begin
      map_preg_d   = sh_preg_d;
      map_pend_d   = sh_pend_d;
      free_d       = sh_free_d;
      ckpt_valid_d = 1'b0;
    end else if (ckpt_en) begin
      sh_preg_d    = map_preg_d;
      sh_pend_d    = map_pend_d;
      sh_free_d    = free_d;
      ckpt_valid_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) map_preg_q[i] <= P'(i);
      map_pend_q <= '0;
      free_q     <= {{(NP - 32){1'b1}}, 32'h0};
    end else begin
      map_preg_q <= map_preg_d;
      map_pend_q <= map_pend_d;
      free_q     <= free_d;
    end
  end

`ifdef RENAME_TABLE_CKPT_EN
  always_ff @(posedge clk) begin
    if (rst) ckpt_valid_q <= 1'b0;
    else     ckpt_valid_q <= ckpt_valid_d;
  end

  // Shadow needs no reset: it is only read while ckpt_valid_q is set.
  always_ff @(posedge clk) begin
    sh_preg_q <= sh_preg_d;
    sh_pend_q <= sh_pend_d;
    sh_free_q <= sh_free_d;
  end
`endif

endmodule
